// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: opcodes, issue FSM states and the queued command record.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SHL = 6'b000101;
  localparam logic [5:0] OP_SHR = 6'b000110;
  localparam logic [5:0] OP_MUL = 6'b000111;
  localparam logic [5:0] OP_CMP = 6'b001000;
  localparam logic [5:0] ALU_OP_MAX = OP_CMP;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic op_legal(input logic [5:0] op);
    return op <= ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// Synchronous command FIFO with async reset; push and pop may share a cycle.
module alu_issue_ctrl_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  // Full blocks a push even when a pop happens in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU initiator: queues decoded commands, runs the start/done handshake with the
// ALU and returns one response per command, in order, over a valid/ready port.
//
// state    | meaning
// ST_IDLE  | waiting for a queued command; pops head when one is present
// ST_ISSUE | alu_start pulse with operands driven; timeout counter cleared
// ST_WAIT  | waiting for alu_done or the timeout
// ST_RESP  | response held on the port until accepted
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [5:0]  i_cmd_op,
  input  logic [7:0]  i_cmd_a,
  input  logic [7:0]  i_cmd_b,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [5:0]  o_alu_op,
  output logic        o_alu_start,
  input  logic [15:0] i_alu_result,
  input  logic        i_alu_done,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_result,
  output logic [5:0]  o_rsp_op,
  output logic        o_rsp_err,
  output logic        o_busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  cmd_t             r_alu_cmd;
  cmd_t             w_cmd_in;
  cmd_t             w_head;
  logic [CMD_W-1:0] w_head_raw;
  logic [TW-1:0]    r_tmo_cnt;
  logic [TW-1:0]    w_tmo_nxt;
  logic [15:0]      r_rsp_result;
  logic [5:0]       r_rsp_op;
  logic             r_rsp_err;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_tmo_hit;

  assign w_cmd_in = '{op: i_cmd_op, a: i_cmd_a, b: i_cmd_b};
  assign w_head   = cmd_t'(w_head_raw);
  assign w_push   = i_cmd_valid && o_cmd_ready;

  alu_issue_ctrl_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_cmd_in),
    .i_pop   (w_pop),
    .o_dout  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_tmo_nxt = r_tmo_cnt + TW'(1);
  assign w_tmo_hit = (w_tmo_nxt == TW'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    o_alu_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = op_legal(w_head.op) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        o_alu_start = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_alu_done || w_tmo_hit) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_cmd    <= '0;
      r_tmo_cnt    <= '0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_rsp_op <= w_head.op;
            // Illegal opcodes never reach the ALU, so the operand bus keeps its last value.
            if (op_legal(w_head.op)) begin
              r_alu_cmd <= w_head;
            end else begin
              r_rsp_result <= '0;
              r_rsp_err    <= 1'b1;
            end
          end
        end
        ST_ISSUE: r_tmo_cnt <= '0;
        ST_WAIT: begin
          if (i_alu_done) begin
            r_rsp_result <= i_alu_result;
            r_rsp_err    <= 1'b0;
          end else begin
            r_tmo_cnt <= w_tmo_nxt;
            if (w_tmo_hit) begin
              r_rsp_result <= '0;
              r_rsp_err    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready  = !w_full && !reset;
  assign o_alu_a      = r_alu_cmd.a;
  assign o_alu_b      = r_alu_cmd.b;
  assign o_alu_op     = r_alu_cmd.op;
  assign o_rsp_valid  = (r_state == ST_RESP);
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_op     = r_rsp_op;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = (r_state != ST_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, corner sequences and a random
// phase, all checked every cycle against a queue-based transaction model.
module tb_alu_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [5:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  alu_a, alu_b;
  logic [5:0]  alu_op;
  logic        alu_start;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [5:0]  rsp_op;
  logic        rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_alu_start(alu_start),
    .i_alu_result(alu_result), .i_alu_done(alu_done),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_op(rsp_op), .o_rsp_err(rsp_err),
    .o_busy(busy)
  );

  typedef struct {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } mcmd_t;

  typedef struct {
    logic [5:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_cyc;
    int          exp_starts;
  } vec_t;

  // Transaction model: command queue plus the one command currently being served.
  mcmd_t       m_q[$];
  bit          m_have, m_resp;
  int          m_age;
  logic [5:0]  m_alu_op;
  logic [7:0]  m_alu_a, m_alu_b;
  logic [15:0] m_res;
  logic [5:0]  m_rop;
  logic        m_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat_q[$];
  bit          spur_en;
  int          alu_wait;
  logic [22:0] rsp_log[$];

  logic        s_cmd_ready, s_alu_start, s_rsp_valid, s_rsp_err, s_busy;
  logic [15:0] s_rsp_result;
  logic [5:0]  s_rsp_op;

  function automatic logic [15:0] alu_fn(input logic [5:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      6'd0:    return {8'h00, a} + {8'h00, b};
      6'd1:    return {8'h00, a} - {8'h00, b};
      default: return {a, b} ^ {10'h000, op};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_issue();
    return m_have && !m_resp && (m_age == 0);
  endfunction

  function automatic bit m_waiting();
    return m_have && !m_resp && (m_age > 0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_have = 0; m_resp = 0; m_age = 0;
    m_alu_op = '0; m_alu_a = '0; m_alu_b = '0;
    m_res = '0; m_rop = '0; m_err = 1'b0;
    alu_wait = 0;
  endtask

  task automatic model_step();
    bit    push;
    mcmd_t c;
    push = cmd_valid && (m_q.size() < DEPTH);
    if (!m_have) begin
      if (m_q.size() > 0) begin
        c = m_q.pop_front();
        m_have = 1; m_age = 0; m_rop = c.op;
        if (c.op <= 6'd8) begin
          m_alu_op = c.op; m_alu_a = c.a; m_alu_b = c.b; m_resp = 0;
        end else begin
          m_resp = 1; m_res = '0; m_err = 1'b1;
        end
      end
    end else if (!m_resp) begin
      if (m_age == 0) m_age = 1;
      else if (alu_done) begin m_resp = 1; m_res = alu_result; m_err = 1'b0; end
      else if (m_age == TMO) begin m_resp = 1; m_res = '0; m_err = 1'b1; end
      else m_age++;
    end else if (rsp_ready) begin
      m_have = 0; m_resp = 0;
    end
    if (push) begin
      c.op = cmd_op; c.a = cmd_a; c.b = cmd_b;
      m_q.push_back(c);
    end
  endtask

  // One clock: drive the ALU side, check at negedge, advance the model at posedge.
  task automatic do_cycle();
    if (m_issue()) begin
      if (lat_q.size() > 0) alu_wait = lat_q.pop_front();
      else alu_wait = ($urandom % 10 == 0) ? 0 : 1 + int'($urandom % 4);
      alu_done   = spur_en && ($urandom % 3 == 0);
      alu_result = 16'($urandom);
    end else if (alu_wait > 0) begin
      alu_wait--;
      alu_done   = (alu_wait == 0);
      alu_result = alu_done ? alu_fn(m_alu_op, m_alu_a, m_alu_b) : 16'($urandom);
    end else begin
      alu_done   = spur_en && !m_waiting() && ($urandom % 5 == 0);
      alu_result = 16'($urandom);
    end
    @(negedge clk);
    s_cmd_ready = cmd_ready; s_alu_start = alu_start; s_rsp_valid = rsp_valid;
    s_rsp_err = rsp_err; s_busy = busy; s_rsp_result = rsp_result; s_rsp_op = rsp_op;
    check("cmd_ready", cmd_ready, m_q.size() < DEPTH);
    check("alu_start", alu_start, m_issue());
    check("rsp_valid", rsp_valid, m_resp);
    check("busy", busy, m_have || (m_q.size() > 0));
    check("alu_abop", {alu_a, alu_b, alu_op}, {m_alu_a, m_alu_b, m_alu_op});
    if (m_resp) check("rsp_fields", {rsp_err, rsp_result, rsp_op}, {m_err, m_res, m_rop});
    if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_err, rsp_result, rsp_op});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [5:0] op, input logic [7:0] a,
                           input logic [7:0] b);
    cmd_valid = v; cmd_op = op; cmd_a = a; cmd_b = b;
  endtask

  task automatic drain(input string name, input int bound);
    int k;
    drive_cmd(0, '0, '0, '0);
    rsp_ready = 1;
    k = 0;
    while ((m_have || m_q.size() > 0) && k < bound) begin do_cycle(); k++; end
    check({name, "_drained"}, k < bound, 1);
    do_cycle();
  endtask

  vec_t vt[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, k, starts;
    bit          found;
    logic [22:0] held;

    vt[0] = '{6'd0,  8'h12, 8'h34, 1, 16'h0046, 1'b0, 3,  1};
    vt[1] = '{6'd1,  8'h05, 8'h07, 2, 16'hFFFE, 1'b0, 4,  1};
    vt[2] = '{6'd3,  8'hAB, 8'hCD, 3, 16'hABCE, 1'b0, 5,  1};
    vt[3] = '{6'd8,  8'h01, 8'h02, 1, 16'h010A, 1'b0, 3,  1};
    vt[4] = '{6'd9,  8'h11, 8'h22, 1, 16'h0000, 1'b1, 1,  0};
    vt[5] = '{6'h10, 8'h33, 8'h44, 1, 16'h0000, 1'b1, 1,  0};
    vt[6] = '{6'd2,  8'h55, 8'h66, 0, 16'h0000, 1'b1, 17, 1};

    reset = 1; spur_en = 0;
    drive_cmd(0, '0, '0, '0);
    rsp_ready = 0; alu_done = 0; alu_result = '0;
    model_reset();
    #1;
    check("reset_outs", {cmd_ready, alu_start, rsp_valid, busy, rsp_err, rsp_result, rsp_op,
                         alu_a, alu_b, alu_op}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("ready_after_reset", cmd_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors, one command at a time into an empty queue.
    for (int i = 0; i < 7; i++) begin
      lat_q.delete();
      if (vt[i].exp_starts != 0) lat_q.push_back(vt[i].lat);
      rsp_ready = 1;
      drive_cmd(1, vt[i].op, vt[i].a, vt[i].b);
      do_cycle();
      drive_cmd(0, '0, '0, '0);
      found = 0; starts = 0;
      for (k = 0; k < 40 && !found; k++) begin
        do_cycle();
        if (s_alu_start) starts++;
        if (s_rsp_valid) begin
          found = 1;
          check("vec_cycle", k, vt[i].exp_cyc);
          check("vec_result", s_rsp_result, vt[i].exp_res);
          check("vec_err", s_rsp_err, vt[i].exp_err);
          check("vec_op", s_rsp_op, vt[i].op);
        end
      end
      check("vec_rsp_seen", found, 1);
      check("vec_starts", starts, vt[i].exp_starts);
      do_cycle();
      check("vec_idle", s_busy, 0);
    end

    // Five commands back-to-back against a stalled ALU; the sixth must be refused.
    lat_q.delete();
    lat_q = '{12, 1, 1, 1, 1};
    rsp_log.delete();
    rsp_ready = 1; acc = 0;
    for (int j = 0; j < 6; j++) begin
      drive_cmd(1, 6'(j + 1), 8'(j * 3), 8'(j + 7));
      do_cycle();
      acc += int'(s_cmd_ready);
      if (j == 5) check("full_ready_low", s_cmd_ready, 0);
    end
    check("full_accepted", acc, 5);
    drive_cmd(0, '0, '0, '0);
    k = 0;
    while (rsp_log.size() < 5 && k < 150) begin do_cycle(); k++; end
    check("full_rsp_count", rsp_log.size(), 5);
    for (int j = 0; j < 5 && j < rsp_log.size(); j++) begin
      check("full_order_op", rsp_log[j][5:0], j + 1);
      check("full_err", rsp_log[j][22], 0);
    end
    drain("full", 60);

    // Timeout on one command, the next queued one still completes normally.
    lat_q.delete();
    lat_q = '{0, 1};
    rsp_log.delete();
    drive_cmd(1, 6'd4, 8'h0F, 8'hF0); do_cycle();
    drive_cmd(1, 6'd0, 8'h20, 8'h22); do_cycle();
    drive_cmd(0, '0, '0, '0);
    k = 0;
    while (rsp_log.size() < 2 && k < 60) begin do_cycle(); k++; end
    check("tmo_rsp_count", rsp_log.size(), 2);
    if (rsp_log.size() >= 2) begin
      check("tmo_first", rsp_log[0], {1'b1, 16'h0000, 6'd4});
      check("tmo_second", rsp_log[1], {1'b0, 16'h0042, 6'd0});
    end
    drain("tmo", 40);

    // Consumer stalls: the response must hold and no new ALU start may appear.
    lat_q.delete();
    lat_q = '{1, 1};
    rsp_ready = 0;
    drive_cmd(1, 6'd4, 8'h3C, 8'hC3); do_cycle();
    drive_cmd(1, 6'd5, 8'h01, 8'h01); do_cycle();
    drive_cmd(0, '0, '0, '0);
    k = 0;
    while (!s_rsp_valid && k < 20) begin do_cycle(); k++; end
    check("stall_rsp_seen", s_rsp_valid, 1);
    held = {s_rsp_err, s_rsp_result, s_rsp_op};
    check("stall_first_rsp", held, {1'b0, 16'h3CC3 ^ 16'h0004, 6'd4});
    for (int j = 0; j < 10; j++) begin
      do_cycle();
      check("stall_hold", {s_rsp_err, s_rsp_result, s_rsp_op}, held);
      check("stall_valid", s_rsp_valid, 1);
      check("stall_no_start", s_alu_start, 0);
    end
    drain("stall", 40);

    // Reset while a command waits on the ALU and two more are queued.
    lat_q.delete();
    lat_q = '{10};
    rsp_ready = 1;
    rsp_log.delete();
    for (int j = 0; j < 3; j++) begin
      drive_cmd(1, 6'(j + 1), 8'(j), 8'(j));
      do_cycle();
    end
    drive_cmd(0, '0, '0, '0);
    check("rst_setup", {m_waiting(), m_q.size() == 2}, 2'b11);
    reset = 1;
    #1;
    check("rst_outs", {cmd_ready, alu_start, rsp_valid, busy, rsp_err, rsp_result, rsp_op,
                       alu_a, alu_b, alu_op}, '0);
    model_reset();
    lat_q.delete();
    alu_done = 0;
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 20; j++) do_cycle();
    check("rst_no_stale_rsp", rsp_log.size(), 0);
    check("rst_idle", s_busy, 0);

    // Random traffic with spurious alu_done and random backpressure.
    spur_en = 1;
    lat_q.delete();
    for (int j = 0; j < 600; j++) begin
      drive_cmd(1'($urandom % 2),
                ($urandom % 5 == 0) ? 6'($urandom) : 6'($urandom % 9),
                8'($urandom), 8'($urandom));
      rsp_ready = ($urandom % 10) < 7;
      do_cycle();
    end
    drain("rand", 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
